// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - single-port integer/branch execution unit; ALU_MDU_EN adds a 3-stage multiplier and collision queue
// One registered result broadcast per cycle to RoB, reservation station and LSB.
module alu_exec_unit #(
   parameter int ROB_W   = 4,
   parameter int Q_DEPTH = 4
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             rdy_in,
   input  logic             clear_in,
   input  logic [5:0]       alu_op,
   input  logic [31:0]      alu_rs1,
   input  logic [31:0]      alu_rs2,
   input  logic [ROB_W-1:0] alu_id,
   output logic             alu_valid,
   output logic [ROB_W-1:0] alu_robid,
   output logic [31:0]      alu_val
);

   localparam logic [5:0] OP_ADD    = 6'd1;
   localparam logic [5:0] OP_SUB    = 6'd2;
   localparam logic [5:0] OP_AND    = 6'd3;
   localparam logic [5:0] OP_OR     = 6'd4;
   localparam logic [5:0] OP_XOR    = 6'd5;
   localparam logic [5:0] OP_SLL    = 6'd6;
   localparam logic [5:0] OP_SRL    = 6'd7;
   localparam logic [5:0] OP_SRA    = 6'd8;
   localparam logic [5:0] OP_SLT    = 6'd9;
   localparam logic [5:0] OP_SLTU   = 6'd10;
   localparam logic [5:0] OP_BEQ    = 6'd11;
   localparam logic [5:0] OP_BNE    = 6'd12;
   localparam logic [5:0] OP_BLT    = 6'd13;
   localparam logic [5:0] OP_BGE    = 6'd14;
   localparam logic [5:0] OP_BLTU   = 6'd15;
   localparam logic [5:0] OP_BGEU   = 6'd16;
   localparam logic [5:0] OP_PASS   = 6'd17;
   localparam logic [5:0] OP_MUL    = 6'd18;
   localparam logic [5:0] OP_MULH   = 6'd19;
   localparam logic [5:0] OP_MULHSU = 6'd20;
   localparam logic [5:0] OP_MULHU  = 6'd21;

   if (Q_DEPTH < 2 || (Q_DEPTH & (Q_DEPTH - 1)) != 0) begin : g_bad_q_depth
      $error("Q_DEPTH must be a power of two and at least 2");
   end

   logic             valid_q, valid_d;
   logic [ROB_W-1:0] robid_q, robid_d;
   logic [31:0]      val_q, val_d;
   logic [31:0]      simple_val;
   logic             dispatch;
   logic [4:0]       shamt;

   assign dispatch = rdy_in && !clear_in && (alu_op != 6'd0);
   assign shamt    = alu_rs2[4:0];

   always_comb begin : simple_alu
      simple_val = 32'd0;
      case (alu_op)
         OP_ADD:  simple_val = alu_rs1 + alu_rs2;
         OP_SUB:  simple_val = alu_rs1 - alu_rs2;
         OP_AND:  simple_val = alu_rs1 & alu_rs2;
         OP_OR:   simple_val = alu_rs1 | alu_rs2;
         OP_XOR:  simple_val = alu_rs1 ^ alu_rs2;
         OP_SLL:  simple_val = alu_rs1 << shamt;
         OP_SRL:  simple_val = alu_rs1 >> shamt;
         OP_SRA:  simple_val = $signed(alu_rs1) >>> shamt;
         OP_SLT:  simple_val = {31'd0, $signed(alu_rs1) < $signed(alu_rs2)};
         OP_SLTU: simple_val = {31'd0, alu_rs1 < alu_rs2};
         OP_BEQ:  simple_val = {31'd0, alu_rs1 == alu_rs2};
         OP_BNE:  simple_val = {31'd0, alu_rs1 != alu_rs2};
         OP_BLT:  simple_val = {31'd0, $signed(alu_rs1) < $signed(alu_rs2)};
         OP_BGE:  simple_val = {31'd0, $signed(alu_rs1) >= $signed(alu_rs2)};
         OP_BLTU: simple_val = {31'd0, alu_rs1 < alu_rs2};
         OP_BGEU: simple_val = {31'd0, alu_rs1 >= alu_rs2};
         OP_PASS: simple_val = alu_rs2;
         default: simple_val = 32'd0;
      endcase
   end

`ifdef ALU_MDU_EN
   localparam int PW = $clog2(Q_DEPTH);
   localparam int CW = PW + 1;

   logic             is_mul;
   logic             fresh_v;
   logic             push;
   logic             pop;
   logic [63:0]      product;

   logic             s1_v_q;
   logic [32:0]      s1_a_q;
   logic [32:0]      s1_b_q;
   logic             s1_hi_q;
   logic [ROB_W-1:0] s1_id_q;
   logic             s2_v_q;
   logic [63:0]      s2_p_q;
   logic             s2_hi_q;
   logic [ROB_W-1:0] s2_id_q;
   logic             s3_v_q;
   logic [31:0]      s3_val_q;
   logic [ROB_W-1:0] s3_id_q;

   logic [ROB_W-1:0] q_id_q  [Q_DEPTH];
   logic [31:0]      q_val_q [Q_DEPTH];
   logic [PW-1:0]    head_q;
   logic [PW-1:0]    tail_q;
   logic [CW-1:0]    cnt_q, cnt_d;

   assign is_mul  = (alu_op >= OP_MUL) && (alu_op <= OP_MULHU);
   assign fresh_v = dispatch && !is_mul;
   // Operands carry a 33rd bit so one signed multiplier serves all four variants.
   assign product = 64'($signed(s1_a_q)) * 64'($signed(s1_b_q));

   always_comb begin : arbitrate
      valid_d = 1'b0;
      robid_d = robid_q;
      val_d   = val_q;
      push    = 1'b0;
      pop     = 1'b0;
      if (s3_v_q) begin
         valid_d = 1'b1;
         robid_d = s3_id_q;
         val_d   = s3_val_q;
         push    = fresh_v;
      end else if (cnt_q != '0) begin
         valid_d = 1'b1;
         robid_d = q_id_q[head_q];
         val_d   = q_val_q[head_q];
         pop     = 1'b1;
         push    = fresh_v;
      end else if (fresh_v) begin
         valid_d = 1'b1;
         robid_d = alu_id;
         val_d   = simple_val;
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1_v_q   <= 1'b0;
         s1_a_q   <= '0;
         s1_b_q   <= '0;
         s1_hi_q  <= 1'b0;
         s1_id_q  <= '0;
         s2_v_q   <= 1'b0;
         s2_p_q   <= '0;
         s2_hi_q  <= 1'b0;
         s2_id_q  <= '0;
         s3_v_q   <= 1'b0;
         s3_val_q <= '0;
         s3_id_q  <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < Q_DEPTH; i++) begin
            q_id_q[i]  <= '0;
            q_val_q[i] <= '0;
         end
      end else if (rdy_in) begin
         if (clear_in) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s3_v_q <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
         end else begin
            s1_v_q   <= dispatch && is_mul;
            s1_a_q   <= {((alu_op == OP_MULH) || (alu_op == OP_MULHSU)) && alu_rs1[31], alu_rs1};
            s1_b_q   <= {(alu_op == OP_MULH) && alu_rs2[31], alu_rs2};
            s1_hi_q  <= (alu_op != OP_MUL);
            s1_id_q  <= alu_id;
            s2_v_q   <= s1_v_q;
            s2_p_q   <= product;
            s2_hi_q  <= s1_hi_q;
            s2_id_q  <= s1_id_q;
            s3_v_q   <= s2_v_q;
            s3_val_q <= s2_hi_q ? s2_p_q[63:32] : s2_p_q[31:0];
            s3_id_q  <= s2_id_q;
            if (push) begin
               q_id_q[tail_q]  <= alu_id;
               q_val_q[tail_q] <= simple_val;
               tail_q          <= tail_q + PW'(1);
            end
            if (pop) begin
               head_q <= head_q + PW'(1);
            end
            cnt_q <= cnt_d;
         end
      end
   end

   // A push into a full queue would silently drop a result.
   always @(posedge clk_in) begin
      if (rst_n_in && rdy_in && !clear_in && push && !pop) begin
         assert (cnt_q < CW'(Q_DEPTH));
      end
   end
`else
   always_comb begin : direct_issue
      valid_d = dispatch;
      robid_d = robid_q;
      val_d   = val_q;
      if (dispatch) begin
         robid_d = alu_id;
         val_d   = simple_val;
      end
   end
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         valid_q <= 1'b0;
         robid_q <= '0;
         val_q   <= '0;
      end else if (rdy_in) begin
         if (clear_in) begin
            valid_q <= 1'b0;
         end else begin
            valid_q <= valid_d;
            robid_q <= robid_d;
            val_q   <= val_d;
         end
      end
   end

   assign alu_valid = valid_q;
   assign alu_robid = robid_q;
   assign alu_val   = val_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized bench for alu_exec_unit against a result-scheduling reference model
// Works with or without ALU_MDU_EN defined.
module tb_alu_exec_unit;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        rdy_in;
   logic        clear_in;
   logic [5:0]  alu_op;
   logic [31:0] alu_rs1;
   logic [31:0] alu_rs2;
   logic [3:0]  alu_id;
   logic        alu_valid;
   logic [3:0]  alu_robid;
   logic [31:0] alu_val;

   int checks   = 0;
   int failures = 0;

`ifdef ALU_MDU_EN
   localparam bit MDU = 1'b1;
`else
   localparam bit MDU = 1'b0;
`endif

   alu_exec_unit #(.ROB_W(4), .Q_DEPTH(4)) dut (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .rdy_in    (rdy_in),
      .clear_in  (clear_in),
      .alu_op    (alu_op),
      .alu_rs1   (alu_rs1),
      .alu_rs2   (alu_rs2),
      .alu_id    (alu_id),
      .alu_valid (alu_valid),
      .alu_robid (alu_robid),
      .alu_val   (alu_val)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] val;
      int          due;
   } res_t;

   res_t        mdu_q[$];
   res_t        bl_q[$];
   int          sedge = 0;
   logic        exp_v = 1'b0;
   logic [3:0]  exp_id = 4'd0;
   logic [31:0] exp_val = 32'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_mul_op(input logic [5:0] op);
      return MDU && (op >= 6'd18) && (op <= 6'd21);
   endfunction

   function automatic logic [31:0] ref_val(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] ps;
      logic [63:0]        pu;
      logic [4:0]         sh;
      sh = b[4:0];
      case (op)
         6'd1:  return a + b;
         6'd2:  return a - b;
         6'd3:  return a & b;
         6'd4:  return a | b;
         6'd5:  return a ^ b;
         6'd6:  return a << sh;
         6'd7:  return a >> sh;
         6'd8:  return 32'($signed(a) >>> sh);
         6'd9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'd10: return (a < b) ? 32'd1 : 32'd0;
         6'd11: return (a == b) ? 32'd1 : 32'd0;
         6'd12: return (a != b) ? 32'd1 : 32'd0;
         6'd13: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'd14: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
         6'd15: return (a < b) ? 32'd1 : 32'd0;
         6'd16: return (a >= b) ? 32'd1 : 32'd0;
         6'd17: return b;
`ifdef ALU_MDU_EN
         6'd18: return a * b;
         6'd19: begin
            ps = 64'(signed'(a)) * 64'(signed'(b));
            return ps[63:32];
         end
         6'd20: begin
            ps = 64'(signed'(a)) * signed'({32'd0, b});
            return ps[63:32];
         end
         6'd21: begin
            pu = {32'd0, a} * {32'd0, b};
            return pu[63:32];
         end
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      mdu_q.delete();
      bl_q.delete();
      exp_v   = 1'b0;
      exp_id  = 4'd0;
      exp_val = 32'd0;
   endtask

   // Each sampled edge: the due multiply wins, then the oldest backlog entry, then the new simple op.
   task automatic model_edge(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] id, input logic rdy, input logic clr);
      res_t fresh;
      bit   have_fresh;
      if (!rdy) return;
      sedge++;
      if (clr) begin
         mdu_q.delete();
         bl_q.delete();
         exp_v = 1'b0;
         return;
      end
      have_fresh = 1'b0;
      if (op != 6'd0) begin
         if (is_mul_op(op)) mdu_q.push_back('{id, ref_val(op, a, b), sedge + 3});
         else begin
            fresh      = '{id, ref_val(op, a, b), sedge};
            have_fresh = 1'b1;
         end
      end
      exp_v = 1'b1;
      if (mdu_q.size() > 0 && mdu_q[0].due == sedge) begin
         fresh = mdu_q.pop_front();
         if (have_fresh) bl_q.push_back('{id, ref_val(op, a, b), sedge});
         have_fresh = 1'b0;
         exp_id = fresh.id;
         exp_val = fresh.val;
      end else if (bl_q.size() > 0) begin
         if (have_fresh) bl_q.push_back(fresh);
         fresh = bl_q.pop_front();
         exp_id = fresh.id;
         exp_val = fresh.val;
      end else if (have_fresh) begin
         exp_id = fresh.id;
         exp_val = fresh.val;
      end else begin
         exp_v = 1'b0;
      end
   endtask

   task automatic cyc(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] id, input logic rdy, input logic clr);
      alu_op   = op;
      alu_rs1  = a;
      alu_rs2  = b;
      alu_id   = id;
      rdy_in   = rdy;
      clear_in = clr;
      @(posedge clk_in);
      #1;
      model_edge(op, a, b, id, rdy, clr);
      check("valid", {31'd0, alu_valid}, {31'd0, exp_v});
      if (exp_v) begin
         check("robid", {28'd0, alu_robid}, {28'd0, exp_id});
         check("val", alu_val, exp_val);
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 4))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [5:0] op;
      int         r;

      rst_n_in = 1'b0;
      rdy_in   = 1'b1;
      clear_in = 1'b0;
      alu_op   = 6'd0;
      alu_rs1  = 32'd0;
      alu_rs2  = 32'd0;
      alu_id   = 4'd0;
      repeat (2) @(posedge clk_in);
      #1;
      check("rst_valid", {31'd0, alu_valid}, 32'd0);
      check("rst_robid", {28'd0, alu_robid}, 32'd0);
      check("rst_val", alu_val, 32'd0);
      rst_n_in = 1'b1;
      model_reset();

      cyc(6'd1, 32'd5, 32'd7, 4'd3, 1'b1, 1'b0);
      check("add_valid", {31'd0, alu_valid}, 32'd1);
      check("add_robid", {28'd0, alu_robid}, 32'd3);
      check("add_val", alu_val, 32'd12);
      cyc(6'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
      check("nop_valid", {31'd0, alu_valid}, 32'd0);

      cyc(6'd8, 32'h8000_0000, 32'h0000_0024, 4'd1, 1'b1, 1'b0);
      check("sra_val", alu_val, 32'hF800_0000);
      cyc(6'd10, 32'd1, 32'hFFFF_FFFF, 4'd2, 1'b1, 1'b0);
      check("sltu_val", alu_val, 32'd1);
      cyc(6'd14, 32'hFFFF_FFFF, 32'd0, 4'd3, 1'b1, 1'b0);
      check("bge_val", alu_val, 32'd0);
      cyc(6'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);

`ifdef ALU_MDU_EN
      cyc(6'd18, 32'd6, 32'd7, 4'd1, 1'b1, 1'b0);
      cyc(6'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
      cyc(6'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
      cyc(6'd1, 32'd1, 32'd1, 4'd2, 1'b1, 1'b0);
      check("mul_first_id", {28'd0, alu_robid}, 32'd1);
      check("mul_first_val", alu_val, 32'd42);
      cyc(6'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
      check("queued_add_id", {28'd0, alu_robid}, 32'd2);
      check("queued_add_val", alu_val, 32'd2);
      cyc(6'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
      check("collide_done", {31'd0, alu_valid}, 32'd0);

      cyc(6'd21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 1'b1, 1'b0);
      repeat (3) cyc(6'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
      check("mulhu_val", alu_val, 32'hFFFF_FFFE);
      cyc(6'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);

      cyc(6'd18, 32'd3, 32'd3, 4'd5, 1'b1, 1'b0);
      cyc(6'd1, 32'd1, 32'd2, 4'd6, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         cyc(6'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
         check("flushed_mul", {31'd0, alu_valid}, 32'd0);
      end
`endif

      cyc(6'd1, 32'd10, 32'd20, 4'd4, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cyc(6'd2, $urandom, $urandom, 4'd9, 1'b0, 1'b0);
         check("hold_valid", {31'd0, alu_valid}, 32'd1);
         check("hold_robid", {28'd0, alu_robid}, 32'd4);
         check("hold_val", alu_val, 32'd30);
      end
      cyc(6'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
      check("post_hold_valid", {31'd0, alu_valid}, 32'd0);

      cyc(6'd4, 32'hF0, 32'h0F, 4'd9, 1'b1, 1'b0);
      #2;
      rst_n_in = 1'b0;
      #1;
      check("async_rst_valid", {31'd0, alu_valid}, 32'd0);
      check("async_rst_robid", {28'd0, alu_robid}, 32'd0);
      check("async_rst_val", alu_val, 32'd0);
      model_reset();
      @(negedge clk_in);
      rst_n_in = 1'b1;
      cyc(6'd2, 32'd3, 32'd5, 4'd6, 1'b1, 1'b0);
      check("sub_after_rst", alu_val, 32'hFFFF_FFFE);

      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 99);
         if (r < 8)       op = 6'd0;
         else if (r < 16) op = 6'($urandom_range(22, 63));
         else             op = 6'($urandom_range(1, 21));
         if (is_mul_op(op) && (mdu_q.size() + bl_q.size() >= 3)) op = 6'd1;
         cyc(op, pick_operand(), pick_operand(), 4'($urandom),
             ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0));
      end
      repeat (6) cyc(6'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
